// File: rtl/button_controller.sv
// button_controller: conditions raw game-pad pins for the CPU register bus.
// Per button: two-flop synchronizer, counter debouncer, sticky press-event latch.
// Registers: LEVEL_INDEX returns debounced levels, EVENT_INDEX returns latched
// press events and clears them on the same edge.
// Optional macro BUTTON_REPEAT_EN adds per-button auto-repeat events while held.
module button_controller #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LEVEL_INDEX     = 0,
  parameter int unsigned EVENT_INDEX     = 2,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   register_read,
  input  logic [6:0]             register_index,
  output logic [15:0]            read_data_o,
  output logic                   read_hit_o,
  output logic [NUM_BUTTONS-1:0] levels_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync0;
  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] stable_next;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] events;
  logic [NUM_BUTTONS-1:0] repeat_fire;
  logic [CW-1:0]          db_count [NUM_BUTTONS];

  logic level_read;
  logic event_read;

  assign level_read = register_read && (register_index == 7'(LEVEL_INDEX));
  assign event_read = register_read && (register_index == 7'(EVENT_INDEX));
  assign levels_o   = stable;

  // Two-flop synchronizer on the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= buttons;
      sync1 <= sync0;
    end
  end

  // Next stable level: accept sync1 once it has differed for DEBOUNCE_CYCLES.
  always_comb begin
    stable_next = stable;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if ((sync1[i] != stable[i]) && (db_count[i] == DB_LAST))
        stable_next[i] = sync1[i];
    end
    rise = stable_next & ~stable;
  end

  // Debounce counters and stable levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) db_count[i] <= '0;
    end else begin
      stable <= stable_next;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (sync1[i] == stable[i] || db_count[i] == DB_LAST)
          db_count[i] <= '0;
        else
          db_count[i] <= db_count[i] + 1'b1;
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX) + 1;

  logic [RW-1:0]          rp_count [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] in_period;

  // Repeat fires when the held counter reaches the current interval end.
  always_comb begin
    repeat_fire = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (stable[i]) begin
        if (in_period[i])
          repeat_fire[i] = (rp_count[i] == RW'(REPEAT_PERIOD - 1));
        else
          repeat_fire[i] = (rp_count[i] == RW'(REPEAT_DELAY - 1));
      end
    end
  end

  // Repeat counters: run while held, reload on fire, clear on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_period <= '0;
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) rp_count[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (!stable[i]) begin
          rp_count[i]  <= '0;
          in_period[i] <= 1'b0;
        end else if (repeat_fire[i]) begin
          rp_count[i]  <= '0;
          in_period[i] <= 1'b1;
        end else begin
          rp_count[i] <= rp_count[i] + 1'b1;
        end
      end
    end
  end
`else
  assign repeat_fire = '0;
`endif

  // Event latch and register read port; new events are OR'd in after the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events      <= '0;
      read_data_o <= '0;
      read_hit_o  <= 1'b0;
    end else begin
      events <= (event_read ? '0 : events) | rise | repeat_fire;
      if (level_read) begin
        read_data_o <= 16'(stable);
        read_hit_o  <= 1'b1;
      end else if (event_read) begin
        read_data_o <= 16'(events);
        read_hit_o  <= 1'b1;
      end else begin
        read_hit_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_controller.sv
// Testbench for button_controller with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Read responses are checked through an expected-value queue.
module tb_button_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  buttons;
  logic        register_read;
  logic [6:0]  register_index;
  logic [15:0] read_data_o;
  logic        read_hit_o;
  logic [3:0]  levels_o;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [15:0] exp_q [$];

  button_controller #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(4),
    .LEVEL_INDEX    (0),
    .EVENT_INDEX    (2),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .buttons       (buttons),
    .register_read (register_read),
    .register_index(register_index),
    .read_data_o   (read_data_o),
    .read_hit_o    (read_hit_o),
    .levels_o      (levels_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle read strobe; a decoded index queues its expected response.
  task automatic do_read(input logic [6:0] idx, input logic [15:0] exp, input bit hit);
    if (hit) exp_q.push_back(exp);
    register_index = idx;
    register_read  = 1'b1;
    tick(1);
    register_read  = 1'b0;
  endtask

  // Monitor: every read hit must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && read_hit_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_hit", read_data_o, 16'hxxxx);
      else check("read_data", read_data_o, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp;
    reset_n = 1'b0;
    buttons = 4'b0000;
    register_read = 1'b0;
    register_index = 7'd0;
    #3;
    check("reset_levels", 16'(levels_o), 16'h0000);
    check("reset_hit", 16'(read_hit_o), 16'h0000);
    check("reset_data", read_data_o, 16'h0000);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Glitch of 3 cycles on button 0 is rejected.
    buttons = 4'b0001;
    tick(3);
    buttons = 4'b0000;
    tick(10);
    check("glitch_levels", 16'(levels_o), 16'h0000);
    do_read(7'd2, 16'h0000, 1'b1);

    // Clean press on button 2: level after exactly 6 edges.
    buttons = 4'b0100;
    tick(5);
    check("press_level_early", 16'(levels_o), 16'h0000);
    tick(1);
    check("press_level", 16'(levels_o), 16'h0004);
    do_read(7'd2, 16'h0004, 1'b1);
    do_read(7'd2, 16'h0000, 1'b1);

    // Event read strobe on the same edge stable[1] rises.
    buttons = 4'b0110;
    tick(5);
    do_read(7'd2, 16'h0000, 1'b1);
    check("collide_level", 16'(levels_o), 16'h0006);
    do_read(7'd2, 16'h0002, 1'b1);

    // Level read leaves events alone; unknown index is not decoded.
    buttons = 4'b1010;
    tick(8);
    check("level_1010", 16'(levels_o), 16'h000A);
    do_read(7'd0, 16'h000A, 1'b1);
    do_read(7'd2, 16'h0008, 1'b1);
    do_read(7'd0, 16'h000A, 1'b1);
    do_read(7'd5, 16'h0000, 1'b0);
    check("idx5_hit", 16'(read_hit_o), 16'h0000);
    check("idx5_data", read_data_o, 16'h000A);

    // Reset mid-count with all pins high.
    buttons = 4'b1111;
    tick(3);
    reset_n = 1'b0;
    #1;
    check("midreset_levels", 16'(levels_o), 16'h0000);
    check("midreset_data", read_data_o, 16'h0000);
    check("midreset_hit", 16'(read_hit_o), 16'h0000);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("post_reset_early", 16'(levels_o), 16'h0000);
    tick(1);
    check("post_reset_level", 16'(levels_o), 16'h000F);
    do_read(7'd2, 16'h000F, 1'b1);

    // Release all, then hold button 3 while reading events every cycle.
    buttons = 4'b0000;
    tick(8);
    check("release_levels", 16'(levels_o), 16'h0000);
    buttons = 4'b1000;
    for (int unsigned e = 1; e <= 56; e++) begin
      exp = 16'h0000;
      if (e == 7) exp = 16'h0008;
`ifdef BUTTON_REPEAT_EN
      if (e == 27 || e == 35 || e == 43 || e == 51) exp = 16'h0008;
`endif
      do_read(7'd2, exp, 1'b1);
    end

    tick(3);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
